seg_scan_decoder: RTL
=====================

# seg_scan_decoder

- Receive-side counterpart of the alarm-clock datapath's multiplexed display outputs.
- Samples the scanned 7-segment bus (`display_out`, `segment_digit`) plus the `am`/`pm`/`dblink` indicators.
- Debounces digit transitions, decodes each segment pattern back to a 4-bit code, and reassembles complete four-digit frames.
- Used in front of test/readback logic: host registers and self-check need the displayed time as numbers, not segments.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical samples required before a digit is accepted (range 1–15).
- `TIMEOUT_CYCLES`, default 1024: cycles without any accepted digit before `stale` asserts (range 2–65535).
- `Clk`  in  1  single system clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `display_out`  in  7  segments a..g, active-high; bit6=a … bit0=g.
- `segment_digit`  in  4  one-hot active-high digit select; bit0 = rightmost digit 0; 4'b0000 = blanking gap.
- `am`, `pm`, `dblink`  in  1 each  indicators, captured at frame commit.
- `digits`  out  16  four 4-bit codes; [3:0] = digit 0; 0–9, 4'hF = blank.
- `am_q`, `pm_q`, `colon_q`  out  1 each  indicator values latched with the last committed frame.
- `frame_valid`  out  1  one-cycle pulse when `digits` is updated.
- `frame_err`  out  1  one-cycle pulse on a protocol or decode error.
- `stale`  out  1  level; no accepted digit for `TIMEOUT_CYCLES`.

## Operation
- All inputs pass through one register stage (`s_*`) before use.
- **Stability counter:** counts cycles for which (`s_segment_digit`, `s_display_out`) equals the previous sample. It reloads to 1 on any change and saturates at `STABLE_CYCLES`. A digit is accepted exactly once per stable run, on the cycle the count reaches `STABLE_CYCLES`. A selector of 4'b0000 is never accepted but does reset the run.
- **Pattern decode:**
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 0000000 = 4'hF
  - Any other pattern is invalid.
- **FSM states:** SYNC, CAPTURE, COMMIT.
  - SYNC: discard accepted digits until digit 0 (4'b0001) is accepted. Store it, set expected index to 1, go to CAPTURE.
  - CAPTURE: an accepted digit must have the expected index. Store it in a shadow register and increment the index. After index 3 is stored, go to COMMIT.
  - COMMIT: for one cycle, copy shadow to `digits`, latch `s_am`/`s_pm`/`s_dblink`, pulse `frame_valid`. Then go to CAPTURE with expected index 0.
  - Error conditions (detected in SYNC or CAPTURE):
    - non-one-hot non-zero selector that has been stable for `STABLE_CYCLES`;
    - out-of-order index;
    - invalid pattern.
  - On any error: pulse `frame_err`, return to SYNC, discard the shadow. `digits` keeps the last good frame.
  - A re-accepted digit with the same index after a blanking gap counts as out-of-order.
- **Timeout counter:** clears on every accepted digit and saturates at `TIMEOUT_CYCLES`. `stale` = (count == `TIMEOUT_CYCLES`). Reaching timeout in CAPTURE forces SYNC without `frame_err`.
- **Reset values:** FSM = SYNC; counters = 0; `digits` = 16'hFFFF; `am_q`/`pm_q`/`colon_q` = 0; pulses = 0; `stale` = 0; input registers = 0. Reset mid-frame discards all partial state.

## Timing
- Input change at edge N is visible in `s_*` after edge N+1.
- A digit held constant from edge N is accepted at edge N+`STABLE_CYCLES`.
- `frame_valid` is high the cycle after digit 3 is accepted; `digits` changes on that same edge.
- `frame_err` is high the cycle after the offending sample is accepted.
- Minimum frame period: 4·`STABLE_CYCLES`+1 cycles. Back-to-back frames are supported: COMMIT and the next digit-0 stability run overlap.
- Simultaneous timeout and error: the error wins (`frame_err` pulses).

## Structure
- Shared package `alarm_pkg`: segment-pattern constants SEG_0…SEG_9 and SEG_BLANK, the blank code 4'hF, and the FSM state encoding.
- Sub-module `seg7_to_bcd`: combinational pattern → {valid, code[3:0]}; reusable by other readback blocks.
- Everything else lives in `seg_scan_decoder`.

## Test plan
All cases use `STABLE_CYCLES`=2.
- **Basic frame:** reset, then scan 0001/1111110, 0010/1111001, 0100/0110000, 1000/1101101, 3 cycles each, `am`=1 → `frame_valid` pulse; `digits`=16'h2130; `am_q`=1.
- **Glitch rejection:** a 1-cycle 1111111 spike between digits → no acceptance; next frame still correct.
- **Blank digit:** digit 3 = 0000000 → `digits`[15:12] = 4'hF; `frame_valid` pulses.
- **Out-of-order:** scan 0001 then 0100 → `frame_err` pulse one cycle after acceptance; `digits` unchanged; next clean frame commits.
- **Invalid pattern:** digit 1 = 1000001 → `frame_err`; return to SYNC.
- **Stall then reset:** stop scanning for 1024 cycles → `stale`=1; resume → `stale`=0. Assert `Reset` low mid-frame → `digits`=16'hFFFF and all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock display readback path.
// Holds the 7-segment pattern constants (bit6=a .. bit0=g), the blank
// code, the scan-decoder FSM state encoding, the decoded-digit payload and
// small selector helpers.
package alarm_pkg;

   localparam int unsigned SEG_W    = 7;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned CODE_W   = 4;
   localparam int unsigned NDIGITS  = 4;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   localparam logic [CODE_W-1:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {
      ST_SYNC    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_COMMIT  = 2'd2
   } scan_state_e;

   // Decoded segment pattern: valid flag plus 4-bit code.
   typedef struct packed {
      logic              valid;
      logic [CODE_W-1:0] code;
   } bcd_s;

   // True when exactly one selector bit is set.
   function automatic logic is_onehot(input logic [SEL_W-1:0] sel);
      return (sel != '0) && ((sel & (sel - SEL_W'(1))) == '0);
   endfunction

   // Digit position of a one-hot selector; 0 for anything else.
   function automatic logic [1:0] sel_index(input logic [SEL_W-1:0] sel);
      case (sel)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bundle between a scanned 7-segment display source and its decoder.
// Scan side : display_out[6:0], segment_digit[3:0], am, pm, dblink.
// Result side: digits[15:0], am_q, pm_q, colon_q, frame_valid, frame_err, stale.
// master = the display/scan source, slave = the decoder.
interface seg_scan_decoder_if;
   import alarm_pkg::*;

   logic [SEG_W-1:0]          display_out;
   logic [SEL_W-1:0]          segment_digit;
   logic                      am;
   logic                      pm;
   logic                      dblink;
   logic [NDIGITS*CODE_W-1:0] digits;
   logic                      am_q;
   logic                      pm_q;
   logic                      colon_q;
   logic                      frame_valid;
   logic                      frame_err;
   logic                      stale;

   modport master (
      output display_out, segment_digit, am, pm, dblink,
      input  digits, am_q, pm_q, colon_q, frame_valid, frame_err, stale
   );

   modport slave (
      input  display_out, segment_digit, am, pm, dblink,
      output digits, am_q, pm_q, colon_q, frame_valid, frame_err, stale
   );

endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to digit-code decoder.
// i_seg   : segments a..g, bit6=a.
// o_bcd_c : {valid, code}; blank pattern gives code 4'hF, unknown patterns
//           give valid=0.
module seg7_to_bcd
   import alarm_pkg::*;
(
   input  logic [SEG_W-1:0] i_seg,
   output bcd_s             o_bcd_c
);

   always_comb begin
      o_bcd_c.valid = 1'b1;
      o_bcd_c.code  = CODE_BLANK;
      case (i_seg)
         SEG_0:     o_bcd_c.code = 4'd0;
         SEG_1:     o_bcd_c.code = 4'd1;
         SEG_2:     o_bcd_c.code = 4'd2;
         SEG_3:     o_bcd_c.code = 4'd3;
         SEG_4:     o_bcd_c.code = 4'd4;
         SEG_5:     o_bcd_c.code = 4'd5;
         SEG_6:     o_bcd_c.code = 4'd6;
         SEG_7:     o_bcd_c.code = 4'd7;
         SEG_8:     o_bcd_c.code = 4'd8;
         SEG_9:     o_bcd_c.code = 4'd9;
         SEG_BLANK: o_bcd_c.code = CODE_BLANK;
         default:   o_bcd_c.valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit 7-segment display scan.
// Debounces each scanned digit, decodes it to a code and reassembles
// complete frames; protocol/decode problems raise a one-cycle error.
// Clk, Reset(async active-low) : clock and reset.
// bus (slave)                  : scan inputs and decoded frame outputs.
module seg_scan_decoder
   import alarm_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic               Clk,
   input  logic               Reset,
   seg_scan_decoder_if.slave  bus
);

   localparam int unsigned SCW      = 4;
   localparam int unsigned TOW      = 16;
   localparam int unsigned SHADOW_W = (NDIGITS - 1) * CODE_W;
   localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
   localparam logic [TOW-1:0] TIMEOUT_MAX = TOW'(TIMEOUT_CYCLES);

   logic [SEL_W-1:0] r_s_seg;
   logic [SEG_W-1:0] r_s_disp;
   logic             r_s_am, r_s_pm, r_s_dblink;
   logic [SCW-1:0]   r_stab_cnt;
   logic             r_acc;
   logic [TOW-1:0]   r_to_cnt;
   logic             r_stale;

   logic             w_same;
   logic [SCW-1:0]   w_stab_nxt;
   logic             w_acc_nxt;
   logic [TOW-1:0]   w_to_nxt;

   // The stability run is measured on the sample entering s_*, so an accept
   // lands on the edge where that sample completes STABLE_CYCLES.
   assign w_same = (bus.segment_digit == r_s_seg) && (bus.display_out == r_s_disp);

   always_comb begin
      w_stab_nxt = SCW'(1);
      if (w_same) begin
         w_stab_nxt = (r_stab_cnt == STABLE_MAX) ? STABLE_MAX : r_stab_cnt + SCW'(1);
      end
      w_acc_nxt = (w_stab_nxt == STABLE_MAX) && (!w_same || (r_stab_cnt != STABLE_MAX))
                  && (bus.segment_digit != '0);
      w_to_nxt  = (r_to_cnt == TIMEOUT_MAX) ? TIMEOUT_MAX : r_to_cnt + TOW'(1);
      if (w_acc_nxt) begin
         w_to_nxt = '0;
      end
   end

   // Input sampling, debounce and timeout tracking.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_s_seg    <= '0;
         r_s_disp   <= '0;
         r_s_am     <= 1'b0;
         r_s_pm     <= 1'b0;
         r_s_dblink <= 1'b0;
         r_stab_cnt <= '0;
         r_acc      <= 1'b0;
         r_to_cnt   <= '0;
         r_stale    <= 1'b0;
      end else begin
         r_s_seg    <= bus.segment_digit;
         r_s_disp   <= bus.display_out;
         r_s_am     <= bus.am;
         r_s_pm     <= bus.pm;
         r_s_dblink <= bus.dblink;
         r_stab_cnt <= w_stab_nxt;
         r_acc      <= w_acc_nxt;
         r_to_cnt   <= w_to_nxt;
         r_stale    <= (w_to_nxt == TIMEOUT_MAX);
      end
   end

   bcd_s w_bcd;

   seg7_to_bcd u_seg7_to_bcd (
      .i_seg   (r_s_disp),
      .o_bcd_c (w_bcd)
   );

   scan_state_e             r_state, w_state_nxt;
   logic [1:0]              r_idx, w_idx_nxt;
   logic [SHADOW_W-1:0]     r_shadow, w_shadow_nxt;
   logic [NDIGITS*CODE_W-1:0] r_digits, w_digits_nxt;
   logic                    r_am_q, r_pm_q, r_colon_q;
   logic                    w_am_nxt, w_pm_nxt, w_colon_nxt;
   logic                    r_frame_valid, r_frame_err;
   logic                    w_fv_nxt, w_fe_nxt;
   logic                    w_bad;
   logic [1:0]              w_pos;

   assign w_bad = !is_onehot(r_s_seg) || !w_bcd.valid;
   assign w_pos = sel_index(r_s_seg);

   // Frame assembly; COMMIT behaves as CAPTURE with index 0 so a digit-0
   // accept overlapping the commit cycle is not lost.
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_shadow_nxt = r_shadow;
      w_digits_nxt = r_digits;
      w_am_nxt     = r_am_q;
      w_pm_nxt     = r_pm_q;
      w_colon_nxt  = r_colon_q;
      w_fv_nxt     = 1'b0;
      w_fe_nxt     = 1'b0;
      case (r_state)
         ST_SYNC: begin
            if (r_acc) begin
               if (w_bad) begin
                  w_fe_nxt = 1'b1;
               end else if (w_pos == 2'd0) begin
                  w_shadow_nxt[3:0] = w_bcd.code;
                  w_idx_nxt         = 2'd1;
                  w_state_nxt       = ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE, ST_COMMIT: begin
            w_state_nxt = ST_CAPTURE;
            if (r_acc) begin
               if (w_bad || (w_pos != r_idx)) begin
                  w_fe_nxt    = 1'b1;
                  w_state_nxt = ST_SYNC;
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
                  case (r_idx)
                     2'd0: w_shadow_nxt[3:0]  = w_bcd.code;
                     2'd1: w_shadow_nxt[7:4]  = w_bcd.code;
                     2'd2: w_shadow_nxt[11:8] = w_bcd.code;
                     default: begin
                        w_digits_nxt = {w_bcd.code, r_shadow};
                        w_am_nxt     = r_s_am;
                        w_pm_nxt     = r_s_pm;
                        w_colon_nxt  = r_s_dblink;
                        w_fv_nxt     = 1'b1;
                        w_state_nxt  = ST_COMMIT;
                     end
                  endcase
               end
            end else if ((r_state == ST_CAPTURE) && r_stale) begin
               w_state_nxt = ST_SYNC;
            end
         end
         default: w_state_nxt = ST_SYNC;
      endcase
   end

   // FSM and registered outputs.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state       <= ST_SYNC;
         r_idx         <= '0;
         r_shadow      <= '0;
         r_digits      <= {NDIGITS{CODE_BLANK}};
         r_am_q        <= 1'b0;
         r_pm_q        <= 1'b0;
         r_colon_q     <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_shadow      <= w_shadow_nxt;
         r_digits      <= w_digits_nxt;
         r_am_q        <= w_am_nxt;
         r_pm_q        <= w_pm_nxt;
         r_colon_q     <= w_colon_nxt;
         r_frame_valid <= w_fv_nxt;
         r_frame_err   <= w_fe_nxt;
      end
   end

   assign bus.digits      = r_digits;
   assign bus.am_q        = r_am_q;
   assign bus.pm_q        = r_pm_q;
   assign bus.colon_q     = r_colon_q;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_err   = r_frame_err;
   assign bus.stale       = r_stale;

endmodule
